// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default sizes, serializer state encoding and
// memoryselect bit positions used by the controller, deserializer and serializer.
package audio_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int ADDR_W_DEF     = 15;
    localparam int CLIP_WORDS_DEF = 32000;
    localparam int CLK_DIV_DEF    = 4;

    // memoryselect bit positions
    localparam int MEMSEL_BLK = 1;
    localparam int MEMSEL_WR  = 0;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        LOAD,
        SHIFT,
        END
    } ser_state_t;

endpackage

// File: rtl/clip_serializer_sclk_gen.sv
// Serial bit-clock generator: while enabled, toggles sclk every CLK_DIV system
// clocks and flags the cycle on which each rising / falling toggle happens.
module sclk_gen
    import audio_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tc;

    assign tc     = en_i && (cnt_q == TC);
    assign rise_o = tc && !sclk_q;
    assign fall_o = tc && sclk_q;
    assign sclk_o = sclk_q;

    // divider count and sclk toggle; disabled means parked low with count cleared
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // divider registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/clip_serializer.sv
// Playback serializer: reads the selected clip word by word from clip memory and
// shifts each word out MSB-first on sclk/lrclk/sdata while seriena is held.
//
// state | meaning
// IDLE  | waiting for seriena with a read select
// PRIME | issue read of word 0
// LOAD  | wait for word 0 read data, then load shift reg
// SHIFT | shifting bits out; next word prefetched into hold reg
// END   | clip finished with seriena still high; wait for it to drop
module clip_serializer
    import audio_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CLIP_WORDS = CLIP_WORDS_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              seriena,
    input  logic [1:0]        memoryselect,
    output logic              mem_rd_en,
    output logic [ADDR_W:0]   mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              busy,
    output logic              done
);

    localparam int                BW        = $clog2(DATA_W + 1);
    localparam logic [BW-1:0]     BITS      = BW'(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(CLIP_WORDS - 1);

    ser_state_t        state_q, state_d;
    logic              blk_q, blk_d;
    logic [ADDR_W-1:0] word_q, word_d;     // index of the word in the shift reg
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              rvld_q;             // mem_rdata valid this cycle
    logic              pf_q, pf_d;         // shift reg was loaded last cycle
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [BW-1:0]     bit_q, bit_d;       // rises left in the current word
    logic              lr_q, lr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_en, sclk_rise, sclk_fall;

    assign sclk_en = (state_q == SHIFT);

    sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clock  (clock),
        .reset_n(reset_n),
        .en_i   (sclk_en),
        .sclk_o (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    assign mem_rd_en = rd_q;
    assign mem_addr  = addr_q;
    assign lrclk     = lr_q;
    assign sdata     = shift_q[DATA_W-1];
    assign busy      = busy_q;
    assign done      = done_q;

    // next state and datapath; seriena only matters at start and word boundaries
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        word_d  = word_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        pf_d    = 1'b0;
        shift_d = shift_q;
        hold_d  = hold_q;
        bit_d   = bit_q;
        lr_d    = lr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (seriena && !memoryselect[MEMSEL_WR]) begin
                    blk_d   = memoryselect[MEMSEL_BLK];
                    word_d  = '0;
                    state_d = PRIME;
                end
            end
            PRIME: begin
                rd_d    = 1'b1;
                addr_d  = {blk_q, word_q};
                state_d = LOAD;
            end
            LOAD: begin
                if (rvld_q) begin
                    shift_d = mem_rdata;
                    bit_d   = BITS;
                    lr_d    = ~lr_q;
                    busy_d  = 1'b1;
                    pf_d    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (pf_q && (word_q != LAST_WORD)) begin
                    rd_d   = 1'b1;
                    addr_d = {blk_q, word_q + 1'b1};
                end
                if (rvld_q) begin
                    hold_d = mem_rdata;
                end
                if (sclk_rise) begin
                    bit_d = bit_q - 1'b1;
                end
                if (sclk_fall) begin
                    if (bit_q == '0) begin
                        if ((word_q == LAST_WORD) || !seriena) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            lr_d    = 1'b0;
                            shift_d = '0;
                            hold_d  = '0;
                            bit_d   = '0;
                            state_d = (word_q == LAST_WORD) ? END : IDLE;
                        end else begin
                            shift_d = hold_q;
                            word_d  = word_q + 1'b1;
                            bit_d   = BITS;
                            lr_d    = ~lr_q;
                            pf_d    = 1'b1;
                        end
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            END: begin
                if (!seriena) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            blk_q   <= 1'b0;
            word_q  <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            rvld_q  <= 1'b0;
            pf_q    <= 1'b0;
            shift_q <= '0;
            hold_q  <= '0;
            bit_q   <= '0;
            lr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            rvld_q  <= rd_q;
            pf_q    <= pf_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            bit_q   <= bit_d;
            lr_q    <= lr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_clip_serializer.sv
// Bench for clip_serializer with a 4-word clip and CLK_DIV=2. A timeline model
// (start edge, cycles into the current word, word index) predicts every output
// each cycle; directed scenarios add hand-computed checks on the serial stream.
module tb_clip_serializer;

    localparam int DW = 16;
    localparam int AW = 15;
    localparam int CW = 4;
    localparam int CD = 2;
    localparam int BP = 2 * CD;      // clocks per bit
    localparam int WL = BP * DW;     // clocks per word

    logic          clock;
    logic          reset_n;
    logic          seriena;
    logic [1:0]    memoryselect;
    logic          mem_rd_en;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          sclk, lrclk, sdata, busy, done;

    logic [DW-1:0] mem [0:1][0:CW-1];

    int vectors;
    int miscompares;

    clip_serializer #(
        .DATA_W(DW), .ADDR_W(AW), .CLIP_WORDS(CW), .CLK_DIV(CD)
    ) dut (
        .clock(clock), .reset_n(reset_n), .seriena(seriena),
        .memoryselect(memoryselect), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
        .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // synchronous-read clip memory
    always @(posedge clock) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[AW]][mem_addr[1:0]];
    end

    // ---------------- timeline model ----------------
    int          m_phase;   // 0 idle, 1 starting, 2 playing, 3 ended with seriena high
    int          m_t;
    int          m_word;
    logic        m_blk;
    logic        exp_rd, exp_done;
    logic [AW:0] exp_addr;

    initial begin
        m_phase = 0; m_t = 0; m_word = 0; m_blk = 1'b0;
        exp_rd = 1'b0; exp_done = 1'b0; exp_addr = '0;
        forever begin
            @(posedge clock);
            exp_rd   = 1'b0;
            exp_done = 1'b0;
            if (!reset_n) begin
                m_phase  = 0;
                exp_addr = '0;
            end else begin
                case (m_phase)
                    0: if (seriena && !memoryselect[0]) begin
                        m_phase = 1; m_t = 0; m_blk = memoryselect[1];
                    end
                    1: begin
                        m_t++;
                        if (m_t == 1) begin exp_rd = 1'b1; exp_addr = {m_blk, AW'(0)}; end
                        if (m_t == 3) begin m_phase = 2; m_t = 0; m_word = 0; end
                    end
                    2: begin
                        m_t++;
                        if (m_t == 1 && m_word < CW - 1) begin
                            exp_rd = 1'b1; exp_addr = {m_blk, AW'(m_word + 1)};
                        end
                        if (m_t == WL) begin
                            if (m_word == CW - 1 || !seriena) begin
                                exp_done = 1'b1;
                                m_phase  = (m_word == CW - 1) ? 3 : 0;
                            end else begin
                                m_word++; m_t = 0;
                            end
                        end
                    end
                    3: if (!seriena) m_phase = 0;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare and stream collectors ----------------
    int          rise_cnt, lr_tog_cnt, done_cnt, rd_cnt, rd_msb0_cnt, busy_cnt;
    logic [63:0] bits_sr, rd_hist;
    logic [AW:0] last_rd_addr;

    initial begin
        logic          e_busy, e_sclk, e_sdata, e_lr;
        logic [DW-1:0] wv;
        logic [21:0]   ev, gv;
        logic          p_sclk, p_lr;
        int            bp;
        rise_cnt = 0; lr_tog_cnt = 0; done_cnt = 0; rd_cnt = 0; rd_msb0_cnt = 0; busy_cnt = 0;
        bits_sr = '0; rd_hist = '0; last_rd_addr = '0;
        p_sclk = 1'b0; p_lr = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                e_busy = (m_phase == 2);
                e_sclk = 1'b0; e_sdata = 1'b0; e_lr = 1'b0;
                if (e_busy) begin
                    wv      = mem[m_blk][m_word];
                    bp      = m_t / BP;
                    e_sclk  = (m_t % BP) >= CD;
                    e_sdata = wv[DW-1-bp];
                    e_lr    = (m_word % 2) == 0;
                end
                ev = {e_busy, e_sclk, e_sdata, e_lr, exp_done, exp_rd, exp_addr};
                gv = {busy, sclk, sdata, lrclk, done, mem_rd_en, mem_addr};
                vectors++;
                if (gv !== ev) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t busy/sclk/sdata/lr/done/rd/addr got %b required %b",
                             $time, gv, ev);
                end
            end
            if (sclk && !p_sclk) begin rise_cnt++; bits_sr = {bits_sr[62:0], sdata}; end
            if (lrclk != p_lr) lr_tog_cnt++;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (mem_rd_en) begin
                rd_cnt++;
                if (!mem_addr[AW]) rd_msb0_cnt++;
                rd_hist = {rd_hist[47:0], mem_addr};
                last_rd_addr = mem_addr;
            end
            p_sclk = sclk;
            p_lr   = lrclk;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic wait_sig(input bit for_done, input int maxc, input string nm);
        int k;
        k = 0;
        while (((for_done && !done) || (!for_done && !busy)) && k < maxc) begin
            @(negedge clock);
            k++;
        end
        vectors++;
        if (k >= maxc) begin
            miscompares++;
            $display("FAIL %s: timed out after %0d cycles, required event", nm, k);
        end
    endtask

    task automatic fill_random();
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < CW; w++)
                mem[b][w] = DW'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        int s_rise, s_lr, s_done, s_rd, s_msb0, s_busy;
        vectors = 0; miscompares = 0;
        reset_n = 1'b0; seriena = 1'b0; memoryselect = 2'b00;
        fill_random();
        tick(2);
        check("reset_outputs", {42'h0, busy, sclk, sdata, lrclk, done, mem_rd_en, mem_addr}, 64'h0);
        reset_n = 1'b1;
        tick(2);

        // directed clip A5A0..A5A3 from block 0
        for (int w = 0; w < CW; w++) mem[0][w] = 16'hA5A0 + DW'(w);
        s_rise = rise_cnt; s_lr = lr_tog_cnt; s_done = done_cnt; s_rd = rd_cnt;
        seriena = 1'b1; memoryselect = 2'b00;
        wait_sig(1'b1, 2000, "clip_done");
        tick(2);
        check("clip_bits", bits_sr, 64'hA5A0_A5A1_A5A2_A5A3);
        check("clip_sclk_rises", 64'(rise_cnt - s_rise), 64'd64);
        check("clip_lr_toggles", 64'(lr_tog_cnt - s_lr), 64'd4);
        check("clip_done_pulses", 64'(done_cnt - s_done), 64'd1);
        check("clip_rd_count", 64'(rd_cnt - s_rd), 64'd4);
        check("clip_rd_addrs", rd_hist, 64'h0000_0001_0002_0003);
        s_rd = rd_cnt;
        tick(20);
        check("end_busy_low", {63'h0, busy}, 64'h0);
        check("end_no_reads", 64'(rd_cnt - s_rd), 64'd0);
        seriena = 1'b0; tick(3);
        seriena = 1'b1; tick(3);
        check("restart_rd_count", 64'(rd_cnt - s_rd), 64'd1);
        check("restart_addr0", {48'h0, last_rd_addr}, 64'h0);
        wait_sig(1'b1, 2000, "restart_done");
        seriena = 1'b0; tick(3);

        // block 1, memoryselect changed mid-play
        fill_random();
        s_rd = rd_cnt; s_msb0 = rd_msb0_cnt;
        memoryselect = 2'b10; seriena = 1'b1;
        tick(100);
        memoryselect = 2'b00;
        wait_sig(1'b1, 2000, "blk1_done");
        tick(2);
        check("blk1_rd_count", 64'(rd_cnt - s_rd), 64'd4);
        check("blk1_msb_low_reads", 64'(rd_msb0_cnt - s_msb0), 64'd0);
        seriena = 1'b0; tick(3);

        // write select never starts playback
        s_rd = rd_cnt; s_busy = busy_cnt;
        memoryselect = 2'b01; seriena = 1'b1;
        tick(100);
        check("wr_no_reads", 64'(rd_cnt - s_rd), 64'd0);
        check("wr_no_busy", 64'(busy_cnt - s_busy), 64'd0);
        seriena = 1'b0; memoryselect = 2'b00; tick(3);

        // seriena drops during bit 5 of word 1
        s_rise = rise_cnt; s_lr = lr_tog_cnt; s_done = done_cnt; s_rd = rd_cnt;
        seriena = 1'b1;
        wait_sig(1'b0, 50, "drop_busy");
        tick(WL + 5 * BP + 1);
        seriena = 1'b0;
        wait_sig(1'b1, 2000, "drop_done");
        tick(4);
        check("drop_sclk_rises", 64'(rise_cnt - s_rise), 64'd32);
        check("drop_lr_toggles", 64'(lr_tog_cnt - s_lr), 64'd2);
        check("drop_done_pulses", 64'(done_cnt - s_done), 64'd1);
        check("drop_rd_count", 64'(rd_cnt - s_rd), 64'd3);
        check("drop_bits", {32'h0, bits_sr[31:0]}, {32'h0, mem[0][0], mem[0][1]});
        check("drop_busy_low", {63'h0, busy}, 64'h0);

        // reset in the middle of shifting
        seriena = 1'b1;
        wait_sig(1'b0, 50, "rst_busy");
        tick(40);
        reset_n = 1'b0;
        #1;
        check("rst_outputs", {42'h0, busy, sclk, sdata, lrclk, done, mem_rd_en, mem_addr}, 64'h0);
        seriena = 1'b0;
        tick(3);
        reset_n = 1'b1;
        s_rd = rd_cnt; s_busy = busy_cnt; s_done = done_cnt;
        tick(10);
        check("rst_stays_idle_rd", 64'(rd_cnt - s_rd), 64'd0);
        check("rst_stays_idle_busy", 64'(busy_cnt - s_busy), 64'd0);
        seriena = 1'b1;
        wait_sig(1'b1, 2000, "rst_resume_done");
        tick(2);
        check("rst_resume_done_cnt", 64'(done_cnt - s_done), 64'd1);
        seriena = 1'b0; tick(3);

        // randomized runs: glitchy or dropping seriena, wandering memoryselect
        for (int r = 0; r < 8; r++) begin
            int mode, drop_at;
            fill_random();
            mode    = int'($urandom_range(0, 1));
            drop_at = int'($urandom_range(20, 300));
            memoryselect = {1'($urandom_range(0, 1)), 1'b0};
            seriena = 1'b1;
            for (int c = 0; c < 400; c++) begin
                @(negedge clock);
                if (busy) memoryselect = 2'($urandom_range(0, 3));
                if (mode == 0) seriena = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
                else if (c == drop_at) seriena = 1'b0;
            end
            seriena = 1'b0; memoryselect = 2'b00;
            tick(WL + 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
